// File: rtl/hls_fp17_mul_core_chn_o_rsci_pkg.sv
// Shared fp17 HLS constants: result width and output-channel state encoding.
package hls_fp17_mul_core_chn_o_rsci_pkg;
  localparam int FP17_W = 17;

  typedef logic [FP17_W-1:0] fp17_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chn_state_e;
endpackage

// File: rtl/hls_fp17_mul_core_chn_o_rsci_if.sv
// Output-channel bundle between the core (master) and the rsci wrapper (slave).
interface hls_fp17_mul_core_chn_o_rsci_if;
  import hls_fp17_mul_core_chn_o_rsci_pkg::*;

  fp17_t chn_o_rsc_z;
  logic  chn_o_rsc_lz;
  logic  chn_o_rsc_vz;
  fp17_t chn_o_rsci_d;
  logic  chn_o_rsci_oswt;
  logic  core_wen;
  logic  core_wten;
  logic  chn_o_rsci_bawt;
  logic  chn_o_rsci_wen_comp;

  modport slave (
    output chn_o_rsc_z, chn_o_rsc_lz, chn_o_rsci_bawt, chn_o_rsci_wen_comp,
    input  chn_o_rsc_vz, chn_o_rsci_d, chn_o_rsci_oswt, core_wen, core_wten
  );

  modport master (
    input  chn_o_rsc_z, chn_o_rsc_lz, chn_o_rsci_bawt, chn_o_rsci_wen_comp,
    output chn_o_rsc_vz, chn_o_rsci_d, chn_o_rsci_oswt, core_wen, core_wten
  );
endinterface

// File: rtl/hls_fp17_mul_core_chn_o_rsci_chn_o_wait_dp.sv
// One-entry holding register with FULL flag; z is driven straight from the register.
module hls_fp17_mul_core_chn_o_rsci_chn_o_wait_dp
  import hls_fp17_mul_core_chn_o_rsci_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  vz,
  input  fp17_t d,
  output fp17_t z,
  output logic  lz
);
  chn_state_e state, state_nxt;
  fp17_t      data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      state <= state_nxt;
      if (load) data <= d;
    end
  end

  // A load while FULL only happens together with a drain, so FULL persists.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL:  if (!load && vz) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign lz = (state == FULL);
  assign z  = data;
endmodule

// File: rtl/hls_fp17_mul_core_chn_o_rsci.sv
// Output channel wrapper: accept/bcwt handshake control around the holding register.
module hls_fp17_mul_core_chn_o_rsci
  import hls_fp17_mul_core_chn_o_rsci_pkg::*;
(
  input logic nvdla_core_clk,
  input logic nvdla_core_rst,
  hls_fp17_mul_core_chn_o_rsci_if.slave chn
);
  logic accept;
  logic bcwt;
  logic lz;

  // bcwt remembers a capture made while the core is held, so the same step is not re-captured.
  assign accept = chn.chn_o_rsci_oswt & ~chn.core_wten & ~bcwt & (~lz | chn.chn_o_rsc_vz);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst)     bcwt <= 1'b0;
    else if (chn.core_wen)  bcwt <= 1'b0;
    else if (accept)        bcwt <= 1'b1;
  end

  assign chn.chn_o_rsci_bawt     = accept | bcwt;
  assign chn.chn_o_rsci_wen_comp = ~chn.chn_o_rsci_oswt | chn.chn_o_rsci_bawt;
  assign chn.chn_o_rsc_lz        = lz;

  hls_fp17_mul_core_chn_o_rsci_chn_o_wait_dp u_wait_dp (
    .clk  (nvdla_core_clk),
    .rst  (nvdla_core_rst),
    .load (accept),
    .vz   (chn.chn_o_rsc_vz),
    .d    (chn.chn_o_rsci_d),
    .z    (chn.chn_o_rsc_z),
    .lz   (lz)
  );
endmodule

// File: tb/tb_hls_fp17_mul_core_chn_o_rsci.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based reference.
module tb_hls_fp17_mul_core_chn_o_rsci;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int failed   = 0;

  hls_fp17_mul_core_chn_o_rsci_if bus ();

  hls_fp17_mul_core_chn_o_rsci dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .chn            (bus)
  );

  always #5 clk = ~clk;

  // Reference: results accepted but not yet transferred, last captured value, bcwt flag.
  logic [16:0] pend[$];
  logic [16:0] m_z    = '0;
  logic        m_bcwt = 1'b0;
  int exp_xfers = 0;
  int obs_xfers = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic elz, input logic [16:0] ez);
    chk("lz_dir", {31'd0, bus.chn_o_rsc_lz}, {31'd0, elz});
    chk("z_dir", {15'd0, bus.chn_o_rsc_z}, {15'd0, ez});
  endtask

  // One core cycle: drive inputs, check everything against the reference, then advance it.
  task automatic cyc(input logic o, input logic w, input logic wt, input logic v,
                     input logic [16:0] dd);
    logic ex_acc, ex_bawt, ex_lz;
    @(negedge clk);
    bus.chn_o_rsci_oswt = o;
    bus.core_wen        = w;
    bus.core_wten       = wt;
    bus.chn_o_rsc_vz    = v;
    bus.chn_o_rsci_d    = dd;
    #1;
    ex_lz   = (pend.size() != 0);
    ex_acc  = o && !wt && !m_bcwt && (!ex_lz || v);
    ex_bawt = ex_acc || m_bcwt;
    chk("lz", {31'd0, bus.chn_o_rsc_lz}, {31'd0, ex_lz});
    chk("z", {15'd0, bus.chn_o_rsc_z}, {15'd0, ex_lz ? pend[0] : m_z});
    chk("accept", {31'd0, dut.accept}, {31'd0, ex_acc});
    chk("bcwt", {31'd0, dut.bcwt}, {31'd0, m_bcwt});
    chk("bawt", {31'd0, bus.chn_o_rsci_bawt}, {31'd0, ex_bawt});
    chk("wen_comp", {31'd0, bus.chn_o_rsci_wen_comp}, {31'd0, !o || ex_bawt});
    if (bus.chn_o_rsc_lz && v) obs_xfers++;
    if (ex_lz && v) begin
      void'(pend.pop_front());
      exp_xfers++;
    end
    if (ex_acc) begin
      pend.push_back(dd);
      m_z = dd;
    end
    if (w) m_bcwt = 1'b0;
    else if (ex_acc) m_bcwt = 1'b1;
  endtask

  initial begin
    bus.chn_o_rsci_oswt = 1'b0;
    bus.core_wen        = 1'b0;
    bus.core_wten       = 1'b0;
    bus.chn_o_rsc_vz    = 1'b0;
    bus.chn_o_rsci_d    = '0;
    #3;
    chk("rst_lz", {31'd0, bus.chn_o_rsc_lz}, 32'd0);
    chk("rst_z", {15'd0, bus.chn_o_rsc_z}, 32'd0);
    chk("rst_bcwt", {31'd0, dut.bcwt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single result through an empty channel.
    cyc(1, 1, 0, 1, 17'h0A5A1);
    cyc(0, 1, 0, 1, 17'h0);
    expect_out(1'b1, 17'h0A5A1);
    cyc(0, 1, 0, 1, 17'h0);
    expect_out(1'b0, 17'h0A5A1);

    // Downstream backpressure holds data; raising vz lets the next result in.
    cyc(1, 1, 0, 0, 17'h00111);
    cyc(1, 1, 0, 0, 17'h00222);
    expect_out(1'b1, 17'h00111);
    cyc(1, 1, 0, 0, 17'h00222);
    cyc(1, 1, 0, 1, 17'h00222);
    cyc(0, 1, 0, 1, 17'h0);
    expect_out(1'b1, 17'h00222);
    cyc(0, 1, 0, 1, 17'h0);

    // Back-to-back streaming without bubbles.
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 1, 0, 1, 17'(k));
      if (k > 1) expect_out(1'b1, 17'(k - 1));
    end
    cyc(0, 1, 0, 1, 17'h0);
    expect_out(1'b1, 17'h4);
    cyc(0, 1, 0, 1, 17'h0);

    // Capture while the core is held elsewhere: exactly one transfer, bcwt clears on core_wen.
    cyc(1, 0, 0, 1, 17'h1FFFF);
    cyc(1, 0, 0, 1, 17'h1FFFF);
    chk("bcwt_set", {31'd0, dut.bcwt}, 32'd1);
    cyc(1, 0, 0, 1, 17'h1FFFF);
    cyc(1, 1, 0, 1, 17'h1FFFF);
    cyc(0, 1, 0, 1, 17'h0);
    chk("bcwt_clr", {31'd0, dut.bcwt}, 32'd0);
    expect_out(1'b0, 17'h1FFFF);

    // Wait-state suppresses accept but not the drain.
    cyc(1, 1, 0, 0, 17'h00333);
    cyc(1, 1, 1, 1, 17'h00444);
    cyc(0, 1, 0, 1, 17'h0);
    expect_out(1'b0, 17'h00333);

    // Reset mid-cycle while FULL and stalled.
    cyc(1, 1, 0, 0, 17'h00555);
    cyc(0, 1, 0, 0, 17'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_lz", {31'd0, bus.chn_o_rsc_lz}, 32'd0);
    chk("arst_z", {15'd0, bus.chn_o_rsc_z}, 32'd0);
    chk("arst_bcwt", {31'd0, dut.bcwt}, 32'd0);
    pend.delete();
    m_z    = '0;
    m_bcwt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 0, 1, 17'h00666);
    cyc(0, 1, 0, 1, 17'h0);
    expect_out(1'b1, 17'h00666);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
          17'($urandom));
    end
    cyc(0, 1, 0, 1, 17'h0);
    cyc(0, 1, 0, 1, 17'h0);
    cyc(0, 1, 0, 1, 17'h0);
    chk("xfer_count", 32'(obs_xfers), 32'(exp_xfers));
    chk("drained", {31'd0, bus.chn_o_rsc_lz}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
